// File: rtl/lc3b_fetch_pkg.sv
// Shared LC-3b fetch types and helpers.
//   lc3b_word         : 16-bit machine word used on every datapath port
//   lc3b_fetch_state  : fetch controller states (FETCH, HOLD, DRAIN)
//   LC3B_INSN_BYTES   : byte distance between consecutive instructions
//   align_word()      : clears bit 0 so an address is word aligned
//   next_insn()       : address of the following instruction (wraps)
package lc3b_fetch_pkg;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } lc3b_fetch_state;

    localparam lc3b_word LC3B_INSN_BYTES = 16'd2;
    localparam lc3b_word LC3B_ALIGN_MASK = 16'hFFFE;

    function automatic lc3b_word align_word(input lc3b_word addr);
        return addr & LC3B_ALIGN_MASK;
    endfunction

    function automatic lc3b_word next_insn(input lc3b_word addr);
        return addr + LC3B_INSN_BYTES;
    endfunction

endpackage

// File: rtl/lc3b_fetch_pc.sv
// Program counter register for the fetch unit.
//   clk        : system clock
//   reset      : synchronous active-high reset, loads RESET_PC (bit 0 cleared)
//   load       : load load_value (bit 0 cleared); wins over inc
//   load_value : new PC value
//   inc        : advance PC by one instruction, wrapping at 16 bits
//   pc         : current PC, always even
module lc3b_fetch_pc
    import lc3b_fetch_pkg::*;
#(
    parameter lc3b_word RESET_PC = 16'h0000
)
(
    input  logic     clk,
    input  logic     reset,
    input  logic     load,
    input  lc3b_word load_value,
    input  logic     inc,
    output lc3b_word pc
);

    lc3b_word pc_r;

    // PC update: reset, then explicit load, then sequential increment
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= align_word(RESET_PC);
        end else if (load) begin
            pc_r <= align_word(load_value);
        end else if (inc) begin
            pc_r <= next_insn(pc_r);
        end else begin
            pc_r <= pc_r;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/lc3b_fetch.sv
// LC-3b instruction fetch unit.
// Owns the PC, issues word reads on the mem_read/mem_resp port, holds each
// fetched word with its PC under a valid/ready handshake towards decode and
// handles redirects from execute, dropping every wrong-path word.
//   clk, reset         : clock and synchronous active-high reset
//   mem_address        : byte address of the current read (always even)
//   mem_read           : read request, held until mem_resp
//   mem_resp/mem_rdata : one-cycle response pulse with its data
//   redirect/redirect_pc : one-cycle restart request and its target
//   ir_valid/ir_ready  : handshake towards decode
//   ir_data/ir_pc      : held instruction and its address
//   ir_pc_next         : ir_pc + 2 (wraps)
//   fetch_count        : instructions handed to decode (wraps)
module lc3b_fetch
    import lc3b_fetch_pkg::*;
#(
    parameter lc3b_word RESET_PC = 16'h0000
)
(
    input  logic     clk,
    input  logic     reset,
    output lc3b_word mem_address,
    output logic     mem_read,
    input  logic     mem_resp,
    input  lc3b_word mem_rdata,
    input  logic     redirect,
    input  lc3b_word redirect_pc,
    output logic     ir_valid,
    input  logic     ir_ready,
    output lc3b_word ir_data,
    output lc3b_word ir_pc,
    output lc3b_word ir_pc_next,
    output lc3b_word fetch_count
);

    lc3b_fetch_state state_r, state_s;
    logic            mem_read_r, mem_read_s;
    logic            ir_valid_r, ir_valid_s;
    lc3b_word        ir_data_r, ir_data_s;
    lc3b_word        ir_pc_r, ir_pc_s;
    lc3b_word        pending_pc_r, pending_pc_s;
    lc3b_word        fetch_count_r, fetch_count_s;

    logic            pc_load_s;
    logic            pc_inc_s;
    lc3b_word        pc_load_value_s;
    lc3b_word        pc_s;
    logic            resp_s;

    // A response only counts when a request is actually outstanding; in the
    // one-cycle gap after a completed request mem_read is low.
    assign resp_s = mem_resp & mem_read_r;

    lc3b_fetch_pc #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .reset      (reset),
        .load       (pc_load_s),
        .load_value (pc_load_value_s),
        .inc        (pc_inc_s),
        .pc         (pc_s)
    );

    // Next-state, next-output and PC control for the fetch controller
    always_comb begin
        state_s         = state_r;
        mem_read_s      = mem_read_r;
        ir_valid_s      = ir_valid_r;
        ir_data_s       = ir_data_r;
        ir_pc_s         = ir_pc_r;
        pending_pc_s    = pending_pc_r;
        fetch_count_s   = fetch_count_r;
        pc_load_s       = 1'b0;
        pc_inc_s        = 1'b0;
        pc_load_value_s = redirect_pc;

        case (state_r)
            FETCH: begin
                ir_valid_s = 1'b0;
                if (redirect) begin
                    if (mem_read_r && !resp_s) begin
                        // Request in flight cannot be aborted: keep the old
                        // address on the bus and remember where to go next.
                        pending_pc_s = align_word(redirect_pc);
                        state_s      = DRAIN;
                        mem_read_s   = 1'b1;
                    end else begin
                        // Either the word just arrived (drop it) or nothing
                        // was outstanding; restart directly at the target.
                        pc_load_s  = 1'b1;
                        state_s    = FETCH;
                        mem_read_s = !resp_s;
                    end
                end else if (resp_s) begin
                    ir_data_s  = mem_rdata;
                    ir_pc_s    = pc_s;
                    ir_valid_s = 1'b1;
                    pc_inc_s   = 1'b1;
                    state_s    = HOLD;
                    mem_read_s = 1'b0;
                end else begin
                    state_s    = FETCH;
                    mem_read_s = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    // Redirect beats ir_ready: the held word is wrong-path.
                    pc_load_s  = 1'b1;
                    ir_valid_s = 1'b0;
                    state_s    = FETCH;
                    mem_read_s = 1'b1;
                end else if (ir_ready) begin
                    fetch_count_s = fetch_count_r + 16'd1;
                    ir_valid_s    = 1'b0;
                    state_s       = FETCH;
                    mem_read_s    = 1'b1;
                end else begin
                    ir_valid_s = 1'b1;
                    state_s    = HOLD;
                    mem_read_s = 1'b0;
                end
            end
            DRAIN: begin
                ir_valid_s = 1'b0;
                if (resp_s) begin
                    // Abandoned word is dropped; a coincident redirect is the
                    // newest target and wins over the stored one.
                    pc_load_s       = 1'b1;
                    pc_load_value_s = redirect ? redirect_pc : pending_pc_r;
                    state_s         = FETCH;
                    mem_read_s      = 1'b0;
                end else if (redirect) begin
                    pending_pc_s = align_word(redirect_pc);
                    state_s      = DRAIN;
                    mem_read_s   = 1'b1;
                end else begin
                    state_s    = DRAIN;
                    mem_read_s = 1'b1;
                end
            end
            default: begin
                ir_valid_s = 1'b0;
                state_s    = FETCH;
                mem_read_s = 1'b0;
            end
        endcase
    end

    // Controller and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= FETCH;
            mem_read_r    <= 1'b0;
            ir_valid_r    <= 1'b0;
            ir_data_r     <= 16'h0000;
            ir_pc_r       <= 16'h0000;
            pending_pc_r  <= 16'h0000;
            fetch_count_r <= 16'h0000;
        end else begin
            state_r       <= state_s;
            mem_read_r    <= mem_read_s;
            ir_valid_r    <= ir_valid_s;
            ir_data_r     <= ir_data_s;
            ir_pc_r       <= ir_pc_s;
            pending_pc_r  <= pending_pc_s;
            fetch_count_r <= fetch_count_s;
        end
    end

    // In DRAIN the PC has not moved yet, so it is still the abandoned address.
    assign mem_address = pc_s;
    assign mem_read    = mem_read_r;
    assign ir_valid    = ir_valid_r;
    assign ir_data     = ir_data_r;
    assign ir_pc       = ir_pc_r;
    assign ir_pc_next  = next_insn(ir_pc_r);
    assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_lc3b_fetch.sv
// Self-checking bench for lc3b_fetch: directed scenarios followed by a
// randomized run checked against a transaction-level model of the stream of
// instructions decode should receive.
module tb_lc3b_fetch;

    logic        clk;
    logic        reset;
    logic [15:0] mem_address;
    logic        mem_read;
    logic        mem_resp;
    logic [15:0] mem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic [15:0] ir_data;
    logic [15:0] ir_pc;
    logic [15:0] ir_pc_next;
    logic [15:0] fetch_count;

    logic        reset2;
    logic [15:0] mem_address2;
    logic        mem_read2;
    logic        mem_resp2;
    logic [15:0] mem_rdata2;
    logic        redirect2;
    logic [15:0] redirect_pc2;
    logic        ir_valid2;
    logic        ir_ready2;
    logic [15:0] ir_data2;
    logic [15:0] ir_pc2;
    logic [15:0] ir_pc_next2;
    logic [15:0] fetch_count2;

    int checks;
    int failures;
    int lat;
    int wait_cnt;

    // Memory image: two fixed words at 0 and 2, a scrambled address elsewhere
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0000) return 16'h1261;
        else if (a == 16'h0002) return 16'h5020;
        else return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    lc3b_fetch #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .mem_address(mem_address), .mem_read(mem_read),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .ir_data(ir_data), .ir_pc(ir_pc), .ir_pc_next(ir_pc_next),
        .fetch_count(fetch_count)
    );

    lc3b_fetch #(.RESET_PC(16'hFFFE)) dut2 (
        .clk(clk), .reset(reset2), .mem_address(mem_address2), .mem_read(mem_read2),
        .mem_resp(mem_resp2), .mem_rdata(mem_rdata2), .redirect(redirect2),
        .redirect_pc(redirect_pc2), .ir_valid(ir_valid2), .ir_ready(ir_ready2),
        .ir_data(ir_data2), .ir_pc(ir_pc2), .ir_pc_next(ir_pc_next2),
        .fetch_count(fetch_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory for dut: answers after lat cycles of continuous request
    always @(posedge clk) begin
        if (reset || !mem_read || mem_resp) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end
    assign mem_resp  = mem_read && (wait_cnt >= lat);
    assign mem_rdata = mem_word(mem_address);

    // Memory for dut2: answers in the request cycle
    assign mem_resp2  = mem_read2;
    assign mem_rdata2 = mem_word(mem_address2);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (ir_valid) break;
            tick();
        end
        chk1("wait_ir_valid", ir_valid, 1'b1);
    endtask

    logic [15:0] exp_pc;
    logic [15:0] exp_count;
    logic        prev_req;
    logic [15:0] prev_addr;
    logic        resp_now;
    int          delivered;

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; reset2 = 1'b1; lat = 0;
        redirect = 1'b0; redirect_pc = 16'h0000; ir_ready = 1'b1;
        redirect2 = 1'b0; redirect_pc2 = 16'h0000; ir_ready2 = 1'b0;
        tick(); tick();

        // Reset state
        chk1 ("rst_mem_read", mem_read, 1'b0);
        chk1 ("rst_ir_valid", ir_valid, 1'b0);
        chk16("rst_ir_data", ir_data, 16'h0000);
        chk16("rst_ir_pc", ir_pc, 16'h0000);
        chk16("rst_fetch_count", fetch_count, 16'h0000);
        chk16("rst_mem_address", mem_address, 16'h0000);

        // Straight-line fetch of two words, ir_ready high
        reset = 1'b0;
        tick();
        chk1 ("f1_mem_read", mem_read, 1'b1);
        chk16("f1_mem_address", mem_address, 16'h0000);
        tick();
        chk1 ("f1_ir_valid", ir_valid, 1'b1);
        chk16("f1_ir_data", ir_data, 16'h1261);
        chk16("f1_ir_pc", ir_pc, 16'h0000);
        chk16("f1_ir_pc_next", ir_pc_next, 16'h0002);
        tick();
        chk1 ("f2_ir_valid_low", ir_valid, 1'b0);
        chk1 ("f2_mem_read", mem_read, 1'b1);
        chk16("f2_mem_address", mem_address, 16'h0002);
        chk16("f2_count", fetch_count, 16'h0001);
        tick();
        chk16("f2_ir_data", ir_data, 16'h5020);
        chk16("f2_ir_pc", ir_pc, 16'h0002);

        // Decode stalls for five cycles in HOLD
        ir_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1 ("stall_ir_valid", ir_valid, 1'b1);
            chk16("stall_ir_data", ir_data, 16'h5020);
            chk1 ("stall_mem_read", mem_read, 1'b0);
            chk16("stall_count", fetch_count, 16'h0001);
        end
        ir_ready = 1'b1;
        tick();
        chk16("f2_count_done", fetch_count, 16'h0002);
        chk16("f3_mem_address", mem_address, 16'h0004);

        // Redirect while a slow request is outstanding
        lat = 3;
        redirect = 1'b1; redirect_pc = 16'h3001;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk1 ("drain_mem_read", mem_read, 1'b1);
            chk16("drain_mem_address", mem_address, 16'h0004);
            chk1 ("drain_ir_valid", ir_valid, 1'b0);
            tick();
        end
        chk1 ("drain_done_mem_read", mem_read, 1'b0);
        chk1 ("drain_done_ir_valid", ir_valid, 1'b0);
        chk16("drain_done_address", mem_address, 16'h3000);
        tick();
        chk1 ("redir_mem_read", mem_read, 1'b1);
        chk16("redir_mem_address", mem_address, 16'h3000);
        ir_ready = 1'b0;
        wait_valid(10);
        chk16("redir_ir_pc", ir_pc, 16'h3000);
        chk16("redir_ir_data", ir_data, mem_word(16'h3000));
        chk16("redir_count", fetch_count, 16'h0002);

        // Redirect coincident with mem_resp in FETCH
        ir_ready = 1'b1;
        tick();
        chk16("same_pre_count", fetch_count, 16'h0003);
        chk16("same_pre_address", mem_address, 16'h3002);
        for (int i = 0; i < 10; i++) begin
            if (mem_resp) break;
            tick();
        end
        chk1("same_resp_seen", mem_resp, 1'b1);
        redirect = 1'b1; redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        chk1 ("same_mem_read_gap", mem_read, 1'b0);
        chk1 ("same_ir_valid", ir_valid, 1'b0);
        tick();
        chk1 ("same_mem_read", mem_read, 1'b1);
        chk16("same_mem_address", mem_address, 16'h0040);
        chk16("same_count", fetch_count, 16'h0003);

        // Redirect and ir_ready together in HOLD
        lat = 0; ir_ready = 1'b0;
        tick();
        chk1 ("hold_ir_valid", ir_valid, 1'b1);
        chk16("hold_ir_pc", ir_pc, 16'h0040);
        ir_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        chk1 ("hold_redir_ir_valid", ir_valid, 1'b0);
        chk16("hold_redir_count", fetch_count, 16'h0003);
        chk1 ("hold_redir_mem_read", mem_read, 1'b1);
        chk16("hold_redir_address", mem_address, 16'h0100);
        tick();
        chk16("hold_redir_ir_pc", ir_pc, 16'h0100);

        // Reset in the middle of DRAIN
        tick();
        chk16("pre_drain_count", fetch_count, 16'h0004);
        lat = 5; redirect = 1'b1; redirect_pc = 16'h0200;
        tick();
        redirect = 1'b0;
        tick();
        chk1 ("mid_drain_mem_read", mem_read, 1'b1);
        chk16("mid_drain_address", mem_address, 16'h0102);
        reset = 1'b1;
        tick();
        chk1 ("mrst_mem_read", mem_read, 1'b0);
        chk1 ("mrst_ir_valid", ir_valid, 1'b0);
        chk16("mrst_ir_data", ir_data, 16'h0000);
        chk16("mrst_ir_pc", ir_pc, 16'h0000);
        chk16("mrst_count", fetch_count, 16'h0000);
        chk16("mrst_address", mem_address, 16'h0000);
        reset = 1'b0; lat = 0;
        tick();
        chk1 ("mrst_restart_read", mem_read, 1'b1);
        chk16("mrst_restart_addr", mem_address, 16'h0000);
        tick();
        chk16("mrst_restart_data", ir_data, 16'h1261);

        // RESET_PC at the top of memory
        reset2 = 1'b0;
        tick();
        chk1 ("top_mem_read", mem_read2, 1'b1);
        chk16("top_mem_address", mem_address2, 16'hFFFE);
        tick();
        chk1 ("top_ir_valid", ir_valid2, 1'b1);
        chk16("top_ir_pc", ir_pc2, 16'hFFFE);
        chk16("top_ir_pc_next", ir_pc_next2, 16'h0000);
        chk16("top_ir_data", ir_data2, mem_word(16'hFFFE));
        ir_ready2 = 1'b1;
        tick();
        ir_ready2 = 1'b0;
        chk16("top_wrap_address", mem_address2, 16'h0000);
        tick();
        chk16("top_wrap_ir_pc", ir_pc2, 16'h0000);
        chk16("top_wrap_ir_data", ir_data2, 16'h1261);

        // Randomized run against the delivered-instruction model
        reset = 1'b1; redirect = 1'b0; ir_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        exp_pc = 16'h0000; exp_count = 16'h0000;
        prev_req = 1'b0; prev_addr = 16'h0000; delivered = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (ir_valid) begin
                chk16("rnd_ir_pc", ir_pc, exp_pc);
                chk16("rnd_ir_data", ir_data, mem_word(exp_pc));
                chk16("rnd_ir_pc_next", ir_pc_next, exp_pc + 16'd2);
            end
            chk16("rnd_count", fetch_count, exp_count);
            chk1("rnd_addr_even", mem_address[0], 1'b0);
            if (prev_req) begin
                chk1 ("rnd_req_held", mem_read, 1'b1);
                chk16("rnd_addr_stable", mem_address, prev_addr);
            end
            lat         = int'($urandom_range(0, 3));
            redirect    = ($urandom_range(0, 7) == 0);
            redirect_pc = 16'($urandom);
            ir_ready    = ($urandom_range(0, 2) != 0);
            resp_now    = mem_read && (wait_cnt >= lat);
            prev_req    = mem_read && !resp_now;
            prev_addr   = mem_address;
            if (redirect) begin
                exp_pc = redirect_pc & 16'hFFFE;
            end else if (ir_valid && ir_ready) begin
                exp_count = exp_count + 16'd1;
                exp_pc    = exp_pc + 16'd2;
                delivered++;
            end
            tick();
        end
        redirect = 1'b0;
        chk1("rnd_progress", delivered >= 100, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lc3b_fetch.md
Name: lc3b_fetch

Overview:
- Instruction fetch unit that produces the 16-bit instruction words consumed by the instruction-register/decode stage.
- Owns the PC and issues word reads to the instruction memory port using the mem_read/mem_resp protocol.
- Holds each fetched word, with its PC, under a valid/ready handshake until decode accepts it.
- Accepts branch/trap/JSR redirects from execute and discards wrong-path fetches.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset; bit 0 is ignored.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset.
- mem_address  output  16  byte address of the instruction read; always even.
- mem_read  output  1  read request; held high until mem_resp.
- mem_resp  input  1  one-cycle pulse; mem_rdata is valid in the same cycle.
- mem_rdata  input  16  instruction word from memory.
- redirect  input  1  one-cycle pulse; fetch must restart at redirect_pc.
- redirect_pc  input  16  redirect target; bit 0 is ignored.
- ir_valid  output  1  ir_data and ir_pc hold an instruction for decode.
- ir_ready  input  1  decode accepts this cycle (drives ir.load).
- ir_data  output  16  fetched instruction word.
- ir_pc  output  16  address of ir_data.
- ir_pc_next  output  16  ir_pc + 2, used as the incremented PC for BR/JSR/TRAP.
- fetch_count  output  16  count of instructions handed to decode; wraps.

Behaviour:
- Reset, applied in any state:
  - pc = RESET_PC & 16'hFFFE; state = FETCH.
  - mem_read = 0, ir_valid = 0, ir_data = 0, ir_pc = 0, fetch_count = 0.
  - pending_pc = 0.
  - mem_read rises on the first cycle after reset deasserts.
  - The memory side shares the same reset, so no stale mem_resp can arrive after reset.
- States: FETCH, HOLD, DRAIN.
- Address and request:
  - mem_read = 1 in FETCH and DRAIN; 0 in HOLD.
  - mem_address is pc in FETCH and the abandoned address in DRAIN. It is stable for the whole request.
- FETCH:
  - On mem_resp with no redirect: capture ir_data = mem_rdata and ir_pc = pc; pc = pc + 2 (mod 2^16, so 16'hFFFE wraps to 16'h0000); go to HOLD.
  - ir_valid = 1 from the next cycle. Minimum latency is request cycle to ir_valid one cycle after mem_resp.
  - On redirect without mem_resp: the request cannot be aborted. pending_pc = redirect_pc & ~1; go to DRAIN; mem_read stays high.
  - On redirect with mem_resp in the same cycle: discard mem_rdata; pc = redirect_pc & ~1; stay in FETCH. The new request starts next cycle because mem_read drops for one cycle.
- HOLD:
  - ir_valid = 1; outputs stay stable until transfer.
  - Transfer occurs when ir_valid && ir_ready && !redirect. Then fetch_count += 1 and the next state is FETCH. ir_valid = 0 and mem_read = 1 in the following cycle (no back-to-back overlap).
  - On redirect, which takes priority over ir_ready: discard the held word; fetch_count is not incremented; pc = redirect_pc & ~1; go to FETCH.
- DRAIN:
  - On mem_resp: discard the data; pc = pending_pc; go to FETCH with mem_read low for one cycle.
  - A further redirect overwrites pending_pc (latest wins).
  - Redirect coincident with mem_resp: the new target is used.
- ir_pc_next is ir_pc + 2, wrapping, and is combinational from ir_pc.
- ir_valid never rises in DRAIN, and a wrong-path word never reaches decode.

Decomposition:
- Add to lc3b_types:
  - typedef lc3b_fetch_state (FETCH, HOLD, DRAIN).
  - constant LC3B_INSN_BYTES = 2.
- Reuse lc3b_word for every 16-bit port.
- One natural sub-module, lc3b_fetch_pc: the PC register with load, +2 increment and bit-0 masking, reused by the PC datapath.

Test Plan:
- Reset, then memory with 1-cycle mem_resp latency, ir_ready tied high, words 16'h1261, 16'h5020 at addresses 0 and 2:
  - mem_address 0, then 2.
  - ir_data 16'h1261 with ir_pc 0 and ir_pc_next 2, then 16'h5020 with ir_pc 2.
  - fetch_count reaches 2.
- ir_ready held low 5 cycles while in HOLD -> ir_valid stays 1, ir_data is stable, mem_read stays 0, fetch_count is unchanged.
- redirect to 16'h3001 in FETCH while mem_resp is delayed 3 cycles:
  - DRAIN holds mem_address.
  - The returned word is dropped and ir_valid stays 0.
  - The next mem_address is 16'h3000.
- redirect and mem_resp in the same FETCH cycle, target 16'h0040 -> the word is dropped; the next request address is 16'h0040.
- redirect and ir_ready in the same HOLD cycle -> no transfer; fetch_count unchanged; ir_valid 0 next cycle; the next fetch is at the target.
- RESET_PC = 16'hFFFE -> first ir_pc 16'hFFFE, ir_pc_next 16'h0000; the second fetch is at 16'h0000.
- reset asserted mid-DRAIN -> the next cycle shows all outputs at their reset values, and fetch restarts at RESET_PC.
